// File: rtl/fifo_sa_byte_packer.sv
// Read side of an 8-bit show-ahead FIFO. Pops bytes and packs them little-endian
// into BYTES_PER_WORD-byte words on a valid/ready stream. A partial word leaves
// after an idle timeout or an explicit flush, with a contiguous byte-enable mask.
module fifo_sa_byte_packer #(
  parameter int BYTES_PER_WORD = 4,
  parameter int FLUSH_TIMEOUT  = 64
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [7:0]                  fifo_q,
  input  logic                        fifo_empty,
  output logic                        fifo_rdreq,
  input  logic                        flush_req,
  output logic [8*BYTES_PER_WORD-1:0] out_data,
  output logic [BYTES_PER_WORD-1:0]   out_byte_en,
  output logic                        out_valid,
  input  logic                        out_ready
);

  localparam int BPW = BYTES_PER_WORD;
  localparam int CW  = $clog2(BPW + 1);
  localparam int IW  = (BPW > 1) ? $clog2(BPW) : 1;
  localparam int TW  = (FLUSH_TIMEOUT > 0) ? $clog2(FLUSH_TIMEOUT + 1) : 1;

  localparam logic [CW-1:0] COUNT_FULL = CW'(BPW);
  localparam logic [TW-1:0] IDLE_MAX   = TW'(FLUSH_TIMEOUT);

  // FLUSH doubles as the flush_pending flag; the other states mirror the byte count.
  typedef enum logic [1:0] {
    S_EMPTY     = 2'd0,
    S_FILL      = 2'd1,
    S_FULL_WAIT = 2'd2,
    S_FLUSH     = 2'd3
  } state_e;

  state_e                state_q, state_d;
  logic [CW-1:0]         count_q, count_d;
  logic [BPW-1:0][7:0]   accum_q, accum_d;
  logic [TW-1:0]         idle_q, idle_d;
  logic [BPW-1:0][7:0]   out_data_q, out_data_d;
  logic [BPW-1:0]        out_byte_en_q, out_byte_en_d;
  logic                  out_valid_q, out_valid_d;

  logic                  flush_pending;
  logic                  slot_free;
  logic                  pop;

  // Pop handshake toward the FIFO; never asserted while it reports empty.
  always_comb begin
    flush_pending = (state_q == S_FLUSH);
    slot_free     = !out_valid_q || out_ready;
    pop           = !reset && !fifo_empty && (count_q < COUNT_FULL) && !flush_pending;
  end

  assign fifo_rdreq  = pop;
  assign out_data    = out_data_q;
  assign out_byte_en = out_byte_en_q;
  assign out_valid   = out_valid_q;

  // Next-state: accumulate popped byte, move words to the output slot, track idle/flush.
  always_comb begin
    logic [CW-1:0] count_fill;
    logic          pending_d;
    logic          emit;
    logic          timeout_hit;

    // NOTE: every signal written here gets a default first, so no latch can be inferred.
    state_d       = state_q;
    count_d       = count_q;
    accum_d       = accum_q;
    idle_d        = idle_q;
    out_data_d    = out_data_q;
    out_byte_en_d = out_byte_en_q;
    out_valid_d   = out_valid_q;
    count_fill    = count_q;
    pending_d     = flush_pending;
    emit          = 1'b0;
    timeout_hit   = 1'b0;

    if (pop) begin
      accum_d[count_q[IW-1:0]] = fifo_q;
      count_fill               = count_q + 1'b1;
    end
    count_d = count_fill;

    // Idle timer only runs on a partial word that is starved for bytes.
    if ((FLUSH_TIMEOUT != 0) && !flush_pending && fifo_empty &&
        (count_q != '0) && (count_q < COUNT_FULL)) begin
      if (idle_q != IDLE_MAX) idle_d = idle_q + 1'b1;
      timeout_hit = (idle_d == IDLE_MAX);
    end else begin
      idle_d = '0;
    end

    if (out_valid_q && out_ready) out_valid_d = 1'b0;

    if (flush_pending) begin
      if (count_q == '0) begin
        pending_d = 1'b0;
      end else if (slot_free) begin
        emit      = 1'b1;
        pending_d = 1'b0;
      end
    end else begin
      if ((count_fill == COUNT_FULL) && slot_free) emit = 1'b1;
      if (flush_req || timeout_hit) pending_d = 1'b1;
    end

    // Unused accumulator bytes are always zero, so a partial word needs no masking.
    if (emit) begin
      out_valid_d   = 1'b1;
      out_data_d    = accum_d;
      for (int k = 0; k < BPW; k++) out_byte_en_d[k] = (k < int'(count_fill));
      accum_d       = '0;
      count_d       = '0;
    end

    if (pending_d)                    state_d = S_FLUSH;
    else if (count_d == '0)           state_d = S_EMPTY;
    else if (count_d == COUNT_FULL)   state_d = S_FULL_WAIT;
    else                              state_d = S_FILL;
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments; the comb block above uses blocking.
    if (reset) begin
      state_q       <= S_EMPTY;
      count_q       <= '0;
      // NOTE: the accumulator is reset as well, because partial words rely on unused bytes being zero.
      accum_q       <= '0;
      idle_q        <= '0;
      out_data_q    <= '0;
      out_byte_en_q <= '0;
      out_valid_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      count_q       <= count_d;
      accum_q       <= accum_d;
      idle_q        <= idle_d;
      out_data_q    <= out_data_d;
      out_byte_en_q <= out_byte_en_d;
      out_valid_q   <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_fifo_sa_byte_packer.sv
// Bench for fifo_sa_byte_packer: a queue-based show-ahead FIFO feeds the packer,
// and expected output words are built from the pushed byte stream.
module tb_fifo_sa_byte_packer;

  localparam int BPW = 4;

  typedef struct {
    logic [8*BPW-1:0] data;
    logic [BPW-1:0]   be;
  } word_t;

  logic               clock;
  logic               reset;
  logic [7:0]         fifo_q;
  logic               fifo_empty;
  logic               fifo_rdreq;
  logic               flush_req;
  logic [8*BPW-1:0]   out_data;
  logic [BPW-1:0]     out_byte_en;
  logic               out_valid;
  logic               out_ready;

  logic [7:0]         fifo_qu[$];
  word_t              exp_words[$];

  int                 n_checks = 0;
  int                 n_pass   = 0;
  int                 n_words  = 0;
  int                 n_pops   = 0;

  logic               hold_q = 1'b0;
  logic [8*BPW-1:0]   hold_data;
  logic [BPW-1:0]     hold_be;

  fifo_sa_byte_packer #(.BYTES_PER_WORD(BPW), .FLUSH_TIMEOUT(64)) dut (
    .clock      (clock),
    .reset      (reset),
    .fifo_q     (fifo_q),
    .fifo_empty (fifo_empty),
    .fifo_rdreq (fifo_rdreq),
    .flush_req  (flush_req),
    .out_data   (out_data),
    .out_byte_en(out_byte_en),
    .out_valid  (out_valid),
    .out_ready  (out_ready)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic drive_fifo();
    fifo_empty = (fifo_qu.size() == 0);
    fifo_q     = (fifo_qu.size() != 0) ? fifo_qu[0] : 8'h00;
  endtask

  task automatic push_byte(input logic [7:0] b);
    fifo_qu.push_back(b);
    drive_fifo();
  endtask

  task automatic expect_word(input logic [8*BPW-1:0] d, input logic [BPW-1:0] be);
    word_t w;
    w.data = d;
    w.be   = be;
    exp_words.push_back(w);
  endtask

  // One clock: sample outputs on the falling edge, score them, then apply the pop.
  task automatic step();
    logic  pop_s;
    word_t w;
    @(negedge clock);
    pop_s = fifo_rdreq;
    if (fifo_empty) check("no_underflow", fifo_rdreq, 0);
    if (!reset && hold_q) begin
      check("hold_valid", out_valid, 1);
      check("hold_data", out_data, hold_data);
      check("hold_be", out_byte_en, hold_be);
    end
    if (!reset && out_valid && out_ready) begin
      if (exp_words.size() == 0) begin
        check("unexpected_word", out_valid, 0);
      end else begin
        w = exp_words.pop_front();
        check("word_data", out_data, w.data);
        check("word_be", out_byte_en, w.be);
      end
      n_words++;
    end
    hold_q    = !reset && out_valid && !out_ready;
    hold_data = out_data;
    hold_be   = out_byte_en;
    @(posedge clock);
    #1;
    if (pop_s && fifo_qu.size() != 0) begin
      void'(fifo_qu.pop_front());
      n_pops++;
    end
    drive_fifo();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget && exp_words.size() != 0; i++) step();
  endtask

  initial begin
    int saved;
    int pushed;
    int k;
    logic [8*BPW-1:0] cur;
    logic [7:0] b;

    reset     = 1'b1;
    flush_req = 1'b0;
    out_ready = 1'b0;
    drive_fifo();

    // Reset state, including rdreq held low even with a byte available.
    run(2);
    check("rst_valid", out_valid, 0);
    check("rst_data", out_data, 0);
    check("rst_be", out_byte_en, 0);
    push_byte(8'h5A);
    #1;
    check("rst_rdreq", fifo_rdreq, 0);
    fifo_qu.delete();
    drive_fifo();
    reset = 1'b0;
    run(2);
    check("post_rst_valid", out_valid, 0);

    // 1: one full word, out_valid the cycle after the 4th pop.
    out_ready = 1'b1;
    foreach (cur[i]) cur[i] = 1'b0;
    push_byte(8'h11); push_byte(8'h22); push_byte(8'h33); push_byte(8'h44);
    expect_word(32'h44332211, 4'hF);
    saved = n_pops;
    for (int i = 0; i < 10 && (n_pops - saved) < 4; i++) step();
    check("t1_pops", n_pops - saved, 4);
    check("t1_latency", out_valid, 1);
    drain(10);
    check("t1_drained", exp_words.size(), 0);

    // 2: backpressure with 12 bytes, then release.
    out_ready = 1'b0;
    for (int i = 1; i <= 12; i++) push_byte(8'(i));
    expect_word(32'h04030201, 4'hF);
    expect_word(32'h08070605, 4'hF);
    expect_word(32'h0C0B0A09, 4'hF);
    run(20);
    #1;
    check("t2_fifo_left", fifo_qu.size(), 4);
    check("t2_rdreq_low", fifo_rdreq, 0);
    check("t2_valid", out_valid, 1);
    check("t2_data", out_data, 32'h04030201);
    out_ready = 1'b1;
    drain(40);
    check("t2_drained", exp_words.size(), 0);
    run(3);

    // 3: idle timeout flushes a partial word.
    saved = n_words;
    push_byte(8'h11); push_byte(8'h22); push_byte(8'h33);
    expect_word(32'h00332211, 4'h7);
    run(64);
    check("t3_no_early", n_words - saved, 0);
    check("t3_no_early_valid", out_valid, 0);
    drain(30);
    check("t3_drained", exp_words.size(), 0);
    run(2);

    // 4: flush with nothing, then with two bytes; new bytes wait for the flush.
    saved = n_words;
    flush_req = 1'b1; step(); flush_req = 1'b0;
    run(4);
    check("t4_empty_flush", n_words - saved, 0);
    push_byte(8'hAA); push_byte(8'hBB);
    expect_word(32'h0000BBAA, 4'h3);
    run(3);
    flush_req = 1'b1; step(); flush_req = 1'b0;
    push_byte(8'hCC); push_byte(8'hDD);
    #1;
    check("t4_rdreq_blocked", fifo_rdreq, 0);
    step();
    check("t4_held_in_fifo", fifo_qu.size(), 2);
    check("t4_valid", out_valid, 1);
    run(4);
    expect_word(32'h0000DDCC, 4'h3);
    flush_req = 1'b1; step(); flush_req = 1'b0;
    drain(10);
    check("t4_drained", exp_words.size(), 0);
    run(2);

    // 5: reset mid-word with a held output word; stale data must not reappear.
    out_ready = 1'b0;
    for (int i = 1; i <= 6; i++) push_byte(8'(i));
    expect_word(32'h04030201, 4'hF);
    run(10);
    check("t5_pre_valid", out_valid, 1);
    reset = 1'b1;
    push_byte(8'h77);
    step();
    #1;
    check("t5_rst_valid", out_valid, 0);
    check("t5_rst_rdreq", fifo_rdreq, 0);
    fifo_qu.delete();
    exp_words.delete();
    drive_fifo();
    reset     = 1'b0;
    out_ready = 1'b1;
    run(2);
    for (int i = 1; i <= 4; i++) push_byte(8'(i));
    expect_word(32'h04030201, 4'hF);
    drain(20);
    check("t5_drained", exp_words.size(), 0);
    run(2);

    // 6: random stream of 1024 bytes against random backpressure.
    saved  = n_words;
    pushed = 0;
    k      = 0;
    cur    = '0;
    for (int i = 0; i < 20000 && (pushed < 1024 || exp_words.size() != 0); i++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      if (pushed < 1024 && $urandom_range(0, 1) == 1) begin
        b = 8'($urandom);
        push_byte(b);
        cur[8*k +: 8] = b;
        k++;
        pushed++;
        if (k == BPW) begin
          expect_word(cur, 4'hF);
          cur = '0;
          k   = 0;
        end
      end
      step();
    end
    check("t6_pushed", pushed, 1024);
    check("t6_drained", exp_words.size(), 0);
    check("t6_fifo_empty", fifo_qu.size(), 0);
    check("t6_word_count", n_words - saved, 256);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
